// File: rtl/dma_rd_stream_pkg.sv
// Shared constants and FSM encoding for the DMA read-stream engine.
package dma_rd_stream_pkg;

  localparam int DMA_BURST_LEN = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SPACE = 3'd1,
    ST_REQ        = 3'd2,
    ST_RECV       = 3'd3,
    ST_DRAIN      = 3'd4
  } state_t;

  function automatic int burst_bytes(input int bus_w);
    return DMA_BURST_LEN * bus_w / 8;
  endfunction

endpackage

// File: rtl/dma_beat_fifo.sv
// Synchronous beat FIFO with occupancy count; read data is registered (1-cycle latency).
module dma_beat_fifo #(
  parameter int W  = 256,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

endmodule

// File: rtl/dma_rd_stream.sv
// Read-stream engine: requests 16-beat bursts when the FIFO can absorb them and
// unpacks each returned beat into OUT_W-bit words on a valid/ready stream.
module dma_rd_stream
  import dma_rd_stream_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BUS_W   = 256,
  parameter int OUT_W   = 32,
  parameter int FIFO_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       n_bursts,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              dma_valid,
  output logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_ready,
  input  logic [BUS_W-1:0]  dma_rdata,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready,
  output state_t            fsm_state
);

  localparam int LANES  = BUS_W / OUT_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int CW     = FIFO_AW + 1;
  localparam logic [CW-1:0]     MAX_OCC     = CW'(DEPTH - DMA_BURST_LEN);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(burst_bytes(BUS_W));
  localparam logic [4:0]        LAST_BEAT   = 5'(DMA_BURST_LEN - 1);

  state_t             state;
  logic [4:0]         beat_cnt;
  logic [15:0]        bursts_left;
  logic [BUS_W-1:0]   fifo_rdata;
  logic               fifo_empty;
  logic               fifo_full;
  logic [CW-1:0]      fifo_count;
  logic               fifo_wr;
  logic               fifo_rd;
  logic               receiving;
  logic               err_set;
  logic               space_ok;
  logic               beat_valid;
  logic [LANE_W-1:0]  lane;
  logic               lane_last;
  logic               fire;

  // Handshake: a word transfers on any cycle where out_valid and out_ready are both high;
  // DMA beats are accepted unconditionally on dma_ready while a burst is outstanding.
  assign receiving = (state == ST_REQ) || (state == ST_RECV);
  // Beats arriving with no burst outstanding are dropped so they never reach the stream.
  assign fifo_wr   = dma_ready && receiving && !fifo_full;
  assign err_set   = dma_ready && (!receiving || fifo_full);
  assign space_ok  = (fifo_count <= MAX_OCC);

  assign lane_last = (lane == LANE_W'(LANES - 1));
  assign fire      = beat_valid && out_ready;
  assign fifo_rd   = !fifo_empty && (!beat_valid || (fire && lane_last));

  dma_beat_fifo #(
    .W  (BUS_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (dma_rdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // The FIFO read register doubles as the unpacker's beat holder.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_valid <= 1'b0;
      lane       <= '0;
    end else if (fifo_rd) begin
      beat_valid <= 1'b1;
      lane       <= '0;
    end else if (fire) begin
      if (lane_last) begin
        beat_valid <= 1'b0;
        lane       <= '0;
      end else begin
        lane <= lane + 1'b1;
      end
    end
  end

  assign out_valid = beat_valid;
  assign out_data  = fifo_rdata[int'(lane)*OUT_W +: OUT_W];
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      dma_valid   <= 1'b0;
      dma_addr    <= '0;
      beat_cnt    <= '0;
      bursts_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (n_bursts == 16'd0) begin
              done <= 1'b1;
            end else begin
              dma_addr    <= base_addr;
              bursts_left <= n_bursts;
              busy        <= 1'b1;
              state       <= ST_WAIT_SPACE;
            end
          end
        end
        ST_WAIT_SPACE: begin
          if (space_ok) begin
            dma_valid <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dma_ready) begin
            dma_valid <= 1'b0;
            beat_cnt  <= 5'd1;
            state     <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (dma_ready) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt    <= '0;
              bursts_left <= bursts_left - 16'd1;
              dma_addr    <= dma_addr + BURST_BYTES;
              state       <= (bursts_left == 16'd1) ? ST_DRAIN : ST_WAIT_SPACE;
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty && !beat_valid) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_rd_stream.sv
// Bench for dma_rd_stream: DMA beat driver, random downstream ready, word scoreboard.
module tb_dma_rd_stream;
  import dma_rd_stream_pkg::*;

  localparam int ADDR_W = 32;
  localparam int BUS_W  = 256;
  localparam int OUT_W  = 32;
  localparam int LANES  = BUS_W / OUT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [15:0]       n_bursts;
  logic              busy;
  logic              done;
  logic              err;
  logic              dma_valid;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_ready;
  logic [BUS_W-1:0]  dma_rdata;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_ready;
  state_t            fsm_state;

  logic [OUT_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int beat_k = 0;
  int done_cnt = 0;
  int req_cnt = 0;
  int pop_cnt = 0;
  int ready_mode = 0;
  bit mon_en = 1'b0;

  dma_rd_stream #(
    .ADDR_W  (ADDR_W),
    .BUS_W   (BUS_W),
    .OUT_W   (OUT_W),
    .FIFO_AW (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .n_bursts  (n_bursts),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dma_valid (dma_valid),
    .dma_addr  (dma_addr),
    .dma_ready (dma_ready),
    .dma_rdata (dma_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .fsm_state (fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // downstream ready: 0 = always ready, 1 = random 50%, 2 = held low
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // monitor / scoreboard
  initial begin
    logic             prev_stall;
    logic             prev_valid;
    logic [OUT_W-1:0] prev_data;
    logic [OUT_W-1:0] exp;
    prev_stall = 1'b0;
    prev_valid = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (dma_valid && !prev_valid) req_cnt++;
      prev_valid = dma_valid;
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!out_valid || out_data !== prev_data) begin
            errors++;
            $display("FAIL hold_stable: valid=%0b data=%h required valid=1 data=%h", out_valid, out_data, prev_data);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got %h with empty expected queue", out_data);
          end else begin
            exp = exp_q.pop_front();
            pop_cnt++;
            if (out_data !== exp) begin
              errors++;
              $display("FAIL word_data: got %h required %h", out_data, exp);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // driver tasks
  function automatic logic [BUS_W-1:0] make_beat(input int k);
    logic [BUS_W-1:0] b;
    for (int l = 0; l < LANES; l++) b[l*OUT_W +: OUT_W] = OUT_W'(k * LANES + l);
    return b;
  endfunction

  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = a; n_bursts = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic dma_burst(input logic [ADDR_W-1:0] exp_addr, input int gap_max, input int nbeats);
    int t = 0;
    @(negedge clk);
    while (!dma_valid && t < 4000) begin @(negedge clk); t++; end
    checks++;
    if (!dma_valid || dma_addr !== exp_addr) begin
      errors++;
      $display("FAIL dma_request: valid=%0b addr=%h required valid=1 addr=%h", dma_valid, dma_addr, exp_addr);
    end
    if (dma_valid) begin
      for (int b = 0; b < nbeats; b++) begin
        @(posedge clk); #1;
        dma_ready = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        dma_ready = 1'b1;
        dma_rdata = make_beat(beat_k);
        for (int l = 0; l < LANES; l++) exp_q.push_back(OUT_W'(beat_k * LANES + l));
        beat_k++;
      end
      @(posedge clk); #1;
      dma_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input int d0, input int p0, input int exp_words);
    int t = 0;
    while (done_cnt == d0 && t < 6000) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL done_count: got %0d pulses required 1", done_cnt - d0);
    end
    checks++;
    if (pop_cnt - p0 != exp_words) begin
      errors++;
      $display("FAIL word_count: got %0d words required %0d", pop_cnt - p0, exp_words);
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drained: leftover=%0d busy=%0b required leftover=0 busy=0", exp_q.size(), busy);
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, err, dma_valid, out_valid} !== 5'b0 || dma_addr !== '0 || out_data !== '0 || fsm_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b err=%0b dv=%0b ov=%0b addr=%h data=%h st=%0d required all 0",
               busy, done, err, dma_valid, out_valid, dma_addr, out_data, fsm_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    int p0 = pop_cnt;
    int r0 = req_cnt;
    beat_k = 0;
    ready_mode = 0;
    do_start(32'h1000, 16'd1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || dma_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_latency_1: busy=%0b dma_valid=%0b required busy=1 dma_valid=0", busy, dma_valid);
    end
    @(negedge clk);
    checks++;
    if (dma_valid !== 1'b1) begin
      errors++;
      $display("FAIL start_latency_2: dma_valid=%0b required 1", dma_valid);
    end
    dma_burst(32'h1000, 0, 16);
    wait_done(d0, p0, 128);
    checks++;
    if (err !== 1'b0 || req_cnt - r0 != 1) begin
      errors++;
      $display("FAIL single_burst: err=%0b requests=%0d required err=0 requests=1", err, req_cnt - r0);
    end
  endtask

  task automatic test_backpressure();
    int d0 = done_cnt;
    int p0 = pop_cnt;
    int r0;
    ready_mode = 2;
    do_start(32'h1000, 16'd3);
    dma_burst(32'h1000, 0, 16);
    dma_burst(32'h1200, 0, 16);
    r0 = req_cnt;
    repeat (60) @(negedge clk);
    checks++;
    if (req_cnt != r0 || dma_valid !== 1'b0 || fsm_state !== ST_WAIT_SPACE) begin
      errors++;
      $display("FAIL fifo_full_hold: new_requests=%0d dma_valid=%0b st=%0d required 0,0,%0d",
               req_cnt - r0, dma_valid, fsm_state, ST_WAIT_SPACE);
    end
    ready_mode = 0;
    dma_burst(32'h1400, 0, 16);
    wait_done(d0, p0, 384);
  endtask

  task automatic test_zero();
    int d0 = done_cnt;
    int r0 = req_cnt;
    do_start(32'h5000, 16'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_bursts_done: done=%0b busy=%0b required done=1 busy=0", done, busy);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (req_cnt != r0 || done_cnt != d0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_bursts_quiet: requests=%0d dones=%0d busy=%0b required 0,1,0", req_cnt - r0, done_cnt - d0, busy);
    end
  endtask

  task automatic test_random();
    int d0 = done_cnt;
    int p0 = pop_cnt;
    ready_mode = 1;
    do_start(32'h3000, 16'd4);
    for (int i = 0; i < 4; i++) dma_burst(32'h3000 + 32'(i) * 32'h200, 3, 16);
    wait_done(d0, p0, 512);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL random_err: err=%0b required 0", err);
    end
    ready_mode = 0;
  endtask

  task automatic test_reset_mid();
    int d0;
    int p0;
    ready_mode = 2;
    do_start(32'h4000, 16'd1);
    dma_burst(32'h4000, 0, 7);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, dma_valid, out_valid} !== 5'b0 || dma_addr !== '0 || out_data !== '0 || fsm_state !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_reset_state: busy=%0b done=%0b err=%0b dv=%0b ov=%0b addr=%h data=%h st=%0d required all 0",
               busy, done, err, dma_valid, out_valid, dma_addr, out_data, fsm_state);
    end
    exp_q.delete();
    mon_en = 1'b1;
    ready_mode = 0;
    d0 = done_cnt;
    p0 = pop_cnt;
    do_start(32'h4000, 16'd1);
    dma_burst(32'h4000, 0, 16);
    wait_done(d0, p0, 128);
  endtask

  task automatic test_err();
    int d0;
    int p0;
    @(posedge clk); #1;
    dma_ready = 1'b1;
    dma_rdata = {BUS_W{1'b1}};
    @(posedge clk); #1;
    dma_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL idle_beat_err: err=%0b required 1", err);
    end
    d0 = done_cnt;
    p0 = pop_cnt;
    do_start(32'h6000, 16'd1);
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err=%0b required 0", err);
    end
    dma_burst(32'h6000, 1, 16);
    wait_done(d0, p0, 128);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_after_run: err=%0b required 0", err);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    n_bursts = '0;
    dma_ready = 1'b0;
    dma_rdata = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_zero();
    test_random();
    test_reset_mid();
    test_err();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
